// File: rtl/bp_cfg_write_sequencer.sv
// bp_cfg_write_sequencer
// Paces host configuration writes onto the per-core cfg channel. A write
// targets one core, or every core in ascending lane order (broadcast). Each
// issued strobe is followed by gap_cycles_p idle cycles. Out-of-range unicast
// core ids are consumed with a one-cycle err_o pulse and no strobe.
// Optional feature: define BP_CFG_SEQ_WRITE_COUNT_EN to add write_count_o,
// a wrapping 32-bit count of issued strobes.
module bp_cfg_write_sequencer #(
  parameter int num_core_p       = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int gap_cycles_p     = 2,
  localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  logic                                   bcast_i,
  input  logic [core_id_width_lp-1:0]            core_id_i,
  input  logic [cfg_addr_width_p-1:0]            addr_i,
  input  logic [cfg_data_width_p-1:0]            data_i,
  output logic [num_core_p-1:0]                  cfg_w_v_o,
  output logic [num_core_p*cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [num_core_p*cfg_data_width_p-1:0] cfg_data_o,
  output logic                                   busy_o,
`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
  output logic [31:0]                            write_count_o,
`endif
  output logic                                   err_o
);

  localparam int gap_w_lp = (gap_cycles_p > 1) ? $clog2(gap_cycles_p) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // One extra bit so num_core_p itself is representable for the range check.
  localparam logic [core_id_width_lp:0]   num_core_lp  = (core_id_width_lp+1)'(num_core_p);
  localparam logic [core_id_width_lp-1:0] last_lane_lp = core_id_width_lp'(num_core_p - 1);

  logic [1:0]                  state_r;
  logic                        bcast_r;
  logic [core_id_width_lp-1:0] lane_r;
  logic [gap_w_lp-1:0]         gap_cnt_r;
  logic                        pending_r;
  logic [cfg_addr_width_p-1:0] addr_r;
  logic [cfg_data_width_p-1:0] data_r;

  logic id_oor;
  logic more_lanes;

  assign id_oor     = ({1'b0, core_id_i} >= num_core_lp);
  // Last lane is found by equality, so the lane counter never wraps.
  assign more_lanes = bcast_r && (lane_r != last_lane_lp);

  // Sequencer FSM: accept, strobe one lane per SEND, pace with GAP cycles.
  // pending_r remembers whether lanes remain, since lane_r already advanced
  // by the time GAP decides where to go.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      bcast_r   <= 1'b0;
      lane_r    <= '0;
      gap_cnt_r <= '0;
      pending_r <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            bcast_r <= bcast_i;
            addr_r  <= addr_i;
            data_r  <= data_i;
            if (!bcast_i && id_oor) begin
              state_r <= ERR;
            end else begin
              state_r <= SEND;
              lane_r  <= bcast_i ? '0 : core_id_i;
            end
          end
        end
        SEND: begin
          pending_r <= more_lanes;
          if (more_lanes) lane_r <= lane_r + core_id_width_lp'(1);
          if (gap_cycles_p > 0) begin
            state_r   <= GAP;
            gap_cnt_r <= gap_w_lp'(gap_cycles_p - 1);
          end else if (more_lanes) begin
            state_r <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt_r == '0) begin
            state_r <= pending_r ? SEND : IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - gap_w_lp'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
  logic [31:0] write_count_r;

  // Count every issued strobe; wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      write_count_r <= '0;
    end else if (state_r == SEND) begin
      write_count_r <= write_count_r + 32'd1;
    end
  end

  assign write_count_o = write_count_r;
`endif

  // Outputs decode from registered state only, so nothing depends on v_i.
  always_comb begin
    cfg_w_v_o = '0;
    if (state_r == SEND) cfg_w_v_o = num_core_p'(1) << lane_r;
  end

  assign ready_o    = (state_r == IDLE);
  assign busy_o     = (state_r != IDLE);
  assign err_o      = (state_r == ERR);
  assign cfg_addr_o = {num_core_p{addr_r}};
  assign cfg_data_o = {num_core_p{data_r}};

endmodule

// File: tb/tb_bp_cfg_write_sequencer.sv
// Bench for bp_cfg_write_sequencer. Two instances: dut_a (4 cores, gap 2)
// and dut_b (3 cores, gap 0, which also makes core id 3 out of range).
// Expected per-cycle traces are built from the request alone.
module tb_bp_cfg_write_sequencer;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic            v_a, bcast_a, ready_a, busy_a, err_a;
  logic [1:0]      id_a;
  logic [AW-1:0]   addr_a;
  logic [DW-1:0]   data_a;
  logic [3:0]      wv_a;
  logic [4*AW-1:0] ao_a;
  logic [4*DW-1:0] do_a;

  logic            v_b, bcast_b, ready_b, busy_b, err_b;
  logic [1:0]      id_b;
  logic [AW-1:0]   addr_b;
  logic [DW-1:0]   data_b;
  logic [2:0]      wv_b;
  logic [3*AW-1:0] ao_b;
  logic [3*DW-1:0] do_b;

`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
  logic [31:0] wc_a, wc_b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int unsigned exp_wc_a = 0;

  bp_cfg_write_sequencer #(.num_core_p(4), .cfg_addr_width_p(AW), .cfg_data_width_p(DW), .gap_cycles_p(2)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_a), .ready_o(ready_a), .bcast_i(bcast_a),
    .core_id_i(id_a), .addr_i(addr_a), .data_i(data_a), .cfg_w_v_o(wv_a),
    .cfg_addr_o(ao_a), .cfg_data_o(do_a), .busy_o(busy_a),
`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
    .write_count_o(wc_a),
`endif
    .err_o(err_a));

  bp_cfg_write_sequencer #(.num_core_p(3), .cfg_addr_width_p(AW), .cfg_data_width_p(DW), .gap_cycles_p(0)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_b), .ready_o(ready_b), .bcast_i(bcast_b),
    .core_id_i(id_b), .addr_i(addr_b), .data_i(data_b), .cfg_w_v_o(wv_b),
    .cfg_addr_o(ao_b), .cfg_data_o(do_b), .busy_o(busy_b),
`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
    .write_count_o(wc_b),
`endif
    .err_o(err_b));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] strobe_of(input int sel);
    return (sel == 0) ? wv_a : {1'b0, wv_b};
  endfunction
  function automatic logic ready_of(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic err_of(input int sel);
    return (sel == 0) ? err_a : err_b;
  endfunction
  function automatic logic [AW-1:0] addr_lane(input int sel, input int l);
    return (sel == 0) ? ao_a[l*AW +: AW] : ao_b[l*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] data_lane(input int sel, input int l);
    return (sel == 0) ? do_a[l*DW +: DW] : do_b[l*DW +: DW];
  endfunction

  task automatic drive(input int sel, input logic v, input logic b, input logic [1:0] id,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 0) begin
      v_a = v; bcast_a = b; id_a = id; addr_a = a; data_a = d;
    end else begin
      v_b = v; bcast_b = b; id_b = id; addr_b = a; data_b = d;
    end
  endtask

  // Issue one request and check every cycle until the sequencer is ready again.
  // With junk set, random requests are presented while busy; they must be ignored.
  task automatic run_req(input int sel, input logic b, input logic [1:0] id,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input bit junk);
    int n, g, waited;
    logic [3:0] exp_st[$];
    bit exp_err[$];
    n = (sel == 0) ? 4 : 3;
    g = (sel == 0) ? 2 : 0;
    if (!b && int'(id) >= n) begin
      exp_st.push_back(4'd0); exp_err.push_back(1'b1);
    end else begin
      for (int l = 0; l < n; l++) begin
        if (b || l == int'(id)) begin
          exp_st.push_back(4'(1 << l)); exp_err.push_back(1'b0);
          for (int k = 0; k < g; k++) begin
            exp_st.push_back(4'd0); exp_err.push_back(1'b0);
          end
        end
      end
    end
    waited = 0;
    while (!ready_of(sel) && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check_eq("ready_before_accept", 64'(ready_of(sel)), 64'd1);
    drive(sel, 1'b1, b, id, a, d);
    @(posedge clk); #1;
    foreach (exp_st[i]) begin
      drive(sel, junk && ($urandom_range(0, 1) == 1), 1'($urandom), 2'($urandom), AW'($urandom), $urandom);
      check_eq("strobe", 64'(strobe_of(sel)), 64'(exp_st[i]));
      check_eq("err", 64'(err_of(sel)), 64'(exp_err[i]));
      check_eq("ready_busy", 64'({ready_of(sel), busy_of(sel)}), 64'b01);
      if (exp_st[i] != 4'd0) begin
        if (sel == 0) exp_wc_a++;
        for (int l = 0; l < n; l++) begin
          check_eq("addr_lane", 64'(addr_lane(sel, l)), 64'(a));
          check_eq("data_lane", 64'(data_lane(sel, l)), 64'(d));
        end
      end
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0, 2'd0, '0, '0);
    check_eq("idle_after", 64'({ready_of(sel), busy_of(sel), err_of(sel), strobe_of(sel)}), 64'b1000000);
`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
    if (sel == 0) check_eq("write_count", 64'(wc_a), 64'(exp_wc_a));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
    drive(1, 1'b0, 1'b0, 2'd0, '0, '0);
    #12;
    check_eq("rst_a_ctrl", 64'({ready_a, busy_a, err_a, wv_a}), 64'b1000000);
    check_eq("rst_a_data", 64'(ao_a) | 64'(do_a[63:0]) | 64'(do_a[127:64]), 64'd0);
    check_eq("rst_b_ctrl", 64'({ready_b, busy_b, err_b, wv_b}), 64'b100000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Unicast, broadcast with gaps
    run_req(0, 1'b0, 2'd2, 16'h0010, 32'hDEADBEEF, 1'b0);
    run_req(0, 1'b1, 2'd0, 16'h0004, 32'h0BAD_CAFE, 1'b0);
    // Gap 0 broadcast then back-to-back unicast, then out-of-range id
    run_req(1, 1'b1, 2'd3, 16'h1234, 32'h5555_AAAA, 1'b0);
    run_req(1, 1'b0, 2'd1, 16'h4321, 32'h0000_0001, 1'b0);
    run_req(1, 1'b0, 2'd3, 16'h7777, 32'h7777_7777, 1'b0);

    // Reset between first and second broadcast strobes
    drive(0, 1'b1, 1'b1, 2'd0, 16'hABCD, 32'h1357_9BDF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
    check_eq("rst_mid_first_strobe", 64'(wv_a), 64'b0001);
    @(posedge clk); #2;
    reset_n = 1'b0;
    exp_wc_a = 0;
    #1;
    check_eq("rst_mid_ctrl", 64'({ready_a, busy_a, err_a, wv_a}), 64'b1000000);
    check_eq("rst_mid_addr", 64'(ao_a), 64'd0);
    check_eq("rst_mid_data", 64'(do_a[63:0]) | 64'(do_a[127:64]), 64'd0);
`ifdef BP_CFG_SEQ_WRITE_COUNT_EN
    check_eq("rst_mid_count", 64'(wc_a), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_eq("no_replay", 64'({ready_a, wv_a}), 64'b10000);
    end

    // Randomized traffic on both instances, including ignored requests while busy
    for (int i = 0; i < 40; i++) begin
      run_req(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 2'($urandom),
              AW'($urandom), $urandom, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
